// File: rtl/fir_mac_filter.sv
// Multi-channel time-multiplexed FIR filter sharing a single multiply-accumulate unit.
// Each accepted sample takes NTAPS MAC cycles, one rounding cycle and one output handshake.
module fir_mac_filter #(
    parameter int DW    = 16,
    parameter int COEFW = 18,
    parameter int NTAPS = 8,
    parameter int NCH   = 2,
    parameter int OUTW  = 16,
    parameter int SHIFT = 17,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int ACCW = DW + COEFW + $clog2(NTAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DW-1:0]    x_tdata,
    input  logic [CHW-1:0]          x_tid,
    input  logic                    x_tvalid,
    output logic                    x_tready,
    input  logic signed [COEFW-1:0] c [NTAPS],
    output logic signed [OUTW-1:0]  y_tdata,
    output logic [CHW-1:0]          y_tid,
    output logic                    y_tsat,
    output logic                    y_tvalid,
    input  logic                    y_tready
);

    localparam int KW = $clog2(NTAPS);
    localparam int PW = DW + COEFW;
    localparam logic [KW-1:0]  K_LAST = KW'(NTAPS - 1);
    localparam logic [CHW:0]   NCH_V  = (CHW + 1)'(NCH);
    localparam logic [ACCW:0]  HALF   = (ACCW + 1)'(1) << (SHIFT - 1);

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

    state_t state, state_next;

    logic signed [DW-1:0]    dline [NCH][NTAPS];
    logic signed [COEFW-1:0] coef [NTAPS];
    logic [CHW-1:0]          ch;
    logic [KW-1:0]           k;
    logic signed [ACCW-1:0]  acc;

    logic                    accept;
    logic                    ch_ok;
    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  acc_add;
    logic signed [ACCW:0]    sum;
    logic signed [ACCW:0]    rnd;
    logic                    sat_hi;
    logic                    sat_lo;
    logic signed [OUTW-1:0]  round_y;

    assign x_tready = (state == IDLE);
    assign accept   = x_tvalid & x_tready;
    assign ch_ok    = ({1'b0, x_tid} < NCH_V);

    // Datapath: one product per cycle, then round-half-up and saturate the sum.
    always_comb begin
        prod    = dline[ch][k] * coef[k];
        acc_add = acc + ACCW'(prod);
        sum     = {acc[ACCW-1], acc} + HALF;
        rnd     = sum >>> SHIFT;
        sat_hi  = !rnd[ACCW] && (rnd[ACCW-1:OUTW-1] != '0);
        sat_lo  = rnd[ACCW] && (~rnd[ACCW-1:OUTW-1] != '0);
        if (sat_hi)
            round_y = {1'b0, {(OUTW-1){1'b1}}};
        else if (sat_lo)
            round_y = {1'b1, {(OUTW-1){1'b0}}};
        else
            round_y = rnd[OUTW-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && ch_ok) state_next = MAC;
            MAC:     if (k == K_LAST) state_next = ROUND;
            ROUND:   state_next = OUT;
            OUT:     if (y_tready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ch       <= '0;
            k        <= '0;
            acc      <= '0;
            y_tdata  <= '0;
            y_tid    <= '0;
            y_tsat   <= 1'b0;
            y_tvalid <= 1'b0;
            for (int i = 0; i < NCH; i++)
                for (int j = 0; j < NTAPS; j++)
                    dline[i][j] <= '0;
            for (int j = 0; j < NTAPS; j++)
                coef[j] <= '0;
        end else begin
            state <= state_next;
            case (state)
                // Samples tagged with an out-of-range channel are consumed silently.
                IDLE: begin
                    if (accept && ch_ok) begin
                        for (int i = 0; i < NCH; i++) begin
                            if (CHW'(i) == x_tid) begin
                                dline[i][0] <= x_tdata;
                                for (int j = 1; j < NTAPS; j++)
                                    dline[i][j] <= dline[i][j-1];
                            end
                        end
                        ch   <= x_tid;
                        coef <= c;
                        acc  <= '0;
                        k    <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_add;
                    k   <= k + 1'b1;
                end
                ROUND: begin
                    y_tdata  <= round_y;
                    y_tsat   <= sat_hi | sat_lo;
                    y_tid    <= ch;
                    y_tvalid <= 1'b1;
                end
                OUT: begin
                    if (y_tready)
                        y_tvalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
